// File: rtl/valu_pkg.sv
// valu_pkg: shared types, widths and funct legality for the vector ALU scheduler.
// Exports funct_e, sched_state_e, LANES/LANE_W/VEC_W and funct_legal().
package valu_pkg;

  localparam int LANES  = 24;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic [2:0] {
    F_ADD = 3'd0,
    F_SUB = 3'd1,
    F_AND = 3'd2,
    F_OR  = 3'd3,
    F_XOR = 3'd4,
    F_MAX = 3'd5
  } funct_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_e;

  // Codes above MAX (6, 7) have no ALU meaning.
  function automatic logic funct_legal(input logic [2:0] f);
    return f <= 3'(F_MAX);
  endfunction

endpackage

// File: rtl/valu_sched_if.sv
// valu_sched_if: request, ALU and response bundle of the vector ALU scheduler.
// master = issue side / ALU model, slave = valu_sched.
interface valu_sched_if;
  import valu_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][VEC_W-1:0]  req_op1;
  logic [1:0][VEC_W-1:0]  req_op2;
  logic [1:0][2:0]        req_funct;

  logic                   alu_flag;
  logic [VEC_W-1:0]       alu_op1;
  logic [VEC_W-1:0]       alu_op2;
  logic [2:0]             alu_funct;
  logic [VEC_W-1:0]       alu_result;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [VEC_W-1:0]       rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid,
    output req_op1,
    output req_op2,
    output req_funct,
    input  req_ready,
    input  alu_flag,
    input  alu_op1,
    input  alu_op2,
    input  alu_funct,
    output alu_result,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_op1,
    input  req_op2,
    input  req_funct,
    output req_ready,
    output alu_flag,
    output alu_op1,
    output alu_op2,
    output alu_funct,
    input  alu_result,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id,
    output rsp_data,
    output rsp_err
  );

endinterface

// File: rtl/valu_rr_arb.sv
// valu_rr_arb: 2-way round-robin grant; r_last moves only on a handshake.
// Ports: clk, rst, i_valid[1:0], i_hs (grant taken), o_grant[1:0] one-hot/zero.
module valu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_hs,
  output logic [1:0] o_grant
);

  logic r_last;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_hs) begin
      r_last <= o_grant[1];
    end
  end

  always_comb begin
    o_grant = 2'b00;
    unique case (i_valid)
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      2'b10:   o_grant = 2'b10;
      2'b01:   o_grant = 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/valu_sched.sv
// valu_sched: issue controller for the 24x8-bit lane vector ALU.
// Ports: clk, rst (sync, high), io_bus (valu_sched_if.slave); param ALU_LAT 1..15.
module valu_sched
  import valu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  valu_sched_if.slave  io_bus
);

  localparam int CW = 4;

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic [VEC_W-1:0] r_op1;
  logic [VEC_W-1:0] r_op2;
  logic [2:0]       r_fn;
  logic             r_id;
  logic [VEC_W-1:0] r_data;
  logic             r_err;

  logic [1:0]       w_grant;
  logic [1:0]       w_rdy;
  logic             w_hs;
  logic             w_id;
  logic             w_legal;
  logic             w_capture;

  valu_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid (io_bus.req_valid),
    .i_hs    (w_hs),
    .o_grant (w_grant)
  );

  // Grant is already masked by req_valid inside the arbiter.
  assign w_rdy   = (r_state == S_IDLE && !rst) ? w_grant : 2'b00;
  assign w_hs    = |w_rdy;
  assign w_id    = w_rdy[1];
  assign w_legal = funct_legal(io_bus.req_funct[w_id]);

  assign w_capture = (r_state == S_EXEC) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (w_legal) begin
            w_state_nxt = S_EXEC;
            w_cnt_nxt   = CW'(ALU_LAT - 1);
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (io_bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Operands stay put from accept until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1  <= '0;
      r_op2  <= '0;
      r_fn   <= '0;
      r_id   <= 1'b0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_op1 <= io_bus.req_op1[w_id];
        r_op2 <= io_bus.req_op2[w_id];
        r_fn  <= io_bus.req_funct[w_id];
        r_id  <= w_id;
        r_err <= !w_legal;
        if (!w_legal) begin
          r_data <= '0;
        end
      end
      if (w_capture) begin
        r_data <= io_bus.alu_result;
      end
    end
  end

  assign io_bus.req_ready = w_rdy;
  assign io_bus.alu_flag  = (r_state == S_EXEC);
  assign io_bus.alu_op1   = r_op1;
  assign io_bus.alu_op2   = r_op2;
  assign io_bus.alu_funct = r_fn;
  assign io_bus.rsp_valid = (r_state == S_RESP);
  assign io_bus.rsp_id    = r_id;
  assign io_bus.rsp_data  = r_data;
  assign io_bus.rsp_err   = r_err;

endmodule
